// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: command/response channel between one requester and the arbiter
interface data_memory_arbiter_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    modport master (output req, we, funct3, addr, wdata, input ready, rvalid, rdata, err);
    modport slave  (input req, we, funct3, addr, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin two-requester sequencer in front of the shared data memory port
module data_memory_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    data_memory_arbiter_if.slave r0,
    data_memory_arbiter_if.slave r1,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [2:0]           mem_funct3,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state, state_next;
    logic        ptr, any_req, win, accept, live;
    logic        cmd_id, cmd_we, cmd_bad, resp_err;
    logic [2:0]  cmd_funct3;
    logic [31:0] cmd_addr, cmd_wdata, load_data, resp_data;
    logic [32:0] cmd_size;

    assign any_req = r0.req | r1.req;
    assign win     = (r0.req & r1.req) ? ptr : r1.req;
    assign accept  = (state == IDLE) & any_req;

    // legality of the latched command (known size, natural alignment, fits in memory) and load masking
    always_comb begin
        cmd_size  = (cmd_funct3 == 3'b000) ? 33'd1 : (cmd_funct3 == 3'b001) ? 33'd2 : 33'd4;
        cmd_bad   = (cmd_funct3 > 3'b010) | ((cmd_funct3 == 3'b001) & cmd_addr[0]) |
                    ((cmd_funct3 == 3'b010) & (|cmd_addr[1:0])) |
                    (({1'b0, cmd_addr} + cmd_size) > 33'(MEM_BYTES));
        load_data = (cmd_funct3 == 3'b000) ? {24'd0, mem_rdata[7:0]} :
                    (cmd_funct3 == 3'b001) ? {16'd0, mem_rdata[15:0]} : mem_rdata;
    end

    // state register; reset abandons any in-flight transaction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // fixed IDLE -> ACCESS -> RESP sequence, leaving IDLE only when someone requests
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = any_req ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // latch the winner's command on accept, capture the response at the end of ACCESS
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= 1'b0;
            cmd_id     <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_funct3 <= 3'd0;
            cmd_addr   <= 32'd0;
            cmd_wdata  <= 32'd0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            ptr        <= ~win;
            cmd_id     <= win;
            cmd_we     <= win ? r1.we : r0.we;
            cmd_funct3 <= win ? r1.funct3 : r0.funct3;
            cmd_addr   <= win ? r1.addr : r0.addr;
            cmd_wdata  <= win ? r1.wdata : r0.wdata;
        end else if (state == ACCESS) begin
            resp_err   <= cmd_bad;
            resp_data  <= (cmd_bad | cmd_we) ? 32'd0 : load_data;
        end
    end

    // memory strobes only in ACCESS of a legal command; responses only to the owning requester
    always_comb begin
        live       = (state == ACCESS) & ~cmd_bad;
        mem_read   = live & ~cmd_we;
        mem_write  = live & cmd_we;
        mem_funct3 = live ? cmd_funct3 : 3'd0;
        mem_addr   = live ? cmd_addr : 32'd0;
        mem_wdata  = live ? cmd_wdata : 32'd0;
        r0.ready   = accept & ~win;
        r1.ready   = accept & win;
        r0.rvalid  = (state == RESP) & ~cmd_id;
        r1.rvalid  = (state == RESP) & cmd_id;
        r0.rdata   = ((state == RESP) & ~cmd_id) ? resp_data : 32'd0;
        r1.rdata   = ((state == RESP) & cmd_id) ? resp_data : 32'd0;
        r0.err     = (state == RESP) & ~cmd_id & resp_err;
        r1.err     = (state == RESP) & cmd_id & resp_err;
    end
endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester arbiter and sequencer in front of the byte-addressed `data_memory`. It shares the single memory port between the core load/store unit (requester 0) and the program loader/DMA path (requester 1). Requests are granted round-robin and alignment/range checks are applied. Each granted transaction runs as a fixed three-phase sequence, so memory strobes are only ever driven for exactly one cycle per legal access.

## Interface
Parameters:
- MEM_BYTES, 1024, memory size in bytes; accesses with addr+size > MEM_BYTES are errors

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- rN_req  input  1  request from requester N (N = 0, 1)
- rN_we  input  1  1 = store, 0 = load
- rN_funct3  input  3  access size: 000 byte, 001 half, 010 word
- rN_addr  input  32  byte address
- rN_wdata  input  32  store data, LSB-aligned
- rN_ready  output  1  request accepted this cycle
- rN_rvalid  output  1  one-cycle completion pulse
- rN_rdata  output  32  load data, zero-extended; valid only with rN_rvalid
- rN_err  output  1  error flag; valid only with rN_rvalid
- mem_read  output  1  to memory MemRead
- mem_write  output  1  to memory MemWrite
- mem_funct3  output  3  to memory funct3
- mem_addr  output  32  to memory endereco
- mem_wdata  output  32  to memory write_data
- mem_rdata  input  32  from memory read_data (combinational)

## Operation
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - Winner selection: if only one rN_req is high, that requester wins. If both are high, the requester named by the priority pointer wins.
  - rN_ready = 1 (combinational) for the winner only.
  - On the clock edge: latch the winner's we/funct3/addr/wdata and its id, toggle the pointer to the other requester, and go to ACCESS.
- Check (computed on the latched command): error if funct3 is not in {000, 001, 010}; or half with addr[0] = 1; or word with addr[1:0] ≠ 00; or addr + size > MEM_BYTES.
- ACCESS (exactly 1 cycle), legal command:
  - mem_funct3/mem_addr/mem_wdata are driven from the latched command.
  - mem_write = we; mem_read = ~we. The memory commits the store on the edge that ends ACCESS.
  - On a load, mem_rdata is registered on that edge, masked to size (byte [7:0], half [15:0], upper bits zero).
- ACCESS, error command: both strobes stay 0, the response data register is set to 0, and err is set.
- RESP (exactly 1 cycle):
  - rN_rvalid = 1 for the latched id only; rN_rdata and rN_err are driven from the response registers.
  - Go to IDLE.
- Store responses: rdata = 0, err = 0 unless the check failed.
- Requester protocol:
  - Fields must stay stable while rN_req is high and rN_ready is low.
  - Dropping req before ready is legal and creates no commitment.
  - After ready, req may stay high for a next transaction. It is considered again only in the following IDLE cycle.
- Outputs to the non-selected requester stay 0 throughout.

## Timing
- Accept edge T (ready high in the cycle ending at T). ACCESS is cycle T..T+1. rvalid is high in cycle T+1..T+2.
- Load-to-use latency: 2 cycles after acceptance. Peak throughput is 1 transaction per 3 cycles.
- Both requesters always high: grants alternate 0, 1, 0, 1…, so neither requester waits more than one transaction.
- Reset values: all rN_ready/rN_rvalid/rN_err = 0; rN_rdata = 0; all mem_* = 0; pointer = requester 0.
- Reset asserted at any time:
  - Immediately returns to IDLE and forces all strobes low. The in-flight transaction is dropped with no response.
  - A store is lost if reset asserts before the edge that ends ACCESS.
- mem_* outputs are 0 in IDLE and RESP. They are never held across two cycles.

## Test plan
- Single load: r0 word load at addr 0x10, memory holds 0xDEADBEEF → r0_ready at T; mem_read high 1 cycle; r0_rvalid at T+1 with rdata 0xDEADBEEF, err 0.
- Store then load:
  - r1 half store 0x1234ABCD at 0x22, then r1 byte load at 0x23 → rdata 0x000000AB.
  - Word load at 0x20 → upper half 0xABCD, low half unchanged.
- Contention: r0 and r1 both held high for 6 transactions → grant order 0,1,0,1,0,1; each rvalid goes to the matching requester only.
- Errors:
  - Word at 0x02, half at 0x11, funct3 = 011, word at 1022 → each returns rvalid with err 1 and rdata 0; mem_write/mem_read never asserted.
- Reset mid-operation: assert reset_n low during ACCESS of a word store at 0x40 → no rvalid, memory at 0x40 unchanged, all outputs 0. The next request after release is granted to r0 if both requesters are requesting.
